// File: rtl/sr_mc_pkg.sv
// Shared types and encodings for the schoolRISCV multi-cycle control unit.
// Holds FSM states, decode classes, immediate selects, ALU codes and opcode fields.
package sr_mc_pkg;

    localparam int unsigned ALU_W = 4;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_e;

    typedef enum logic [2:0] {
        C_ALU, C_ALU_IMM, C_LUI, C_LOAD, C_STORE, C_BRANCH, C_ILLEGAL
    } class_e;

    localparam logic [1:0] IMM_I = 2'd0;
    localparam logic [1:0] IMM_S = 2'd1;
    localparam logic [1:0] IMM_B = 2'd2;
    localparam logic [1:0] IMM_U = 2'd3;

    localparam logic [ALU_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'd1;
    localparam logic [ALU_W-1:0] ALU_SRL  = 4'd2;
    localparam logic [ALU_W-1:0] ALU_SLTU = 4'd3;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'd4;
    localparam logic [ALU_W-1:0] ALU_SLT  = 4'd5;

    localparam logic [6:0] RVOP_ALU    = 7'b0110011;
    localparam logic [6:0] RVOP_ADDI   = 7'b0010011;
    localparam logic [6:0] RVOP_LUI    = 7'b0110111;
    localparam logic [6:0] RVOP_BRANCH = 7'b1100011;
    localparam logic [6:0] RVOP_LOAD   = 7'b0000011;
    localparam logic [6:0] RVOP_STORE  = 7'b0100011;

    localparam logic [2:0] RVF3_ADD  = 3'b000;
    localparam logic [2:0] RVF3_OR   = 3'b110;
    localparam logic [2:0] RVF3_SRL  = 3'b101;
    localparam logic [2:0] RVF3_SLTU = 3'b011;
    localparam logic [2:0] RVF3_BEQ  = 3'b000;
    localparam logic [2:0] RVF3_BNE  = 3'b001;
    localparam logic [2:0] RVF3_BLT  = 3'b100;
    localparam logic [2:0] RVF3_BGE  = 3'b101;
    localparam logic [2:0] RVF3_BLTU = 3'b110;
    localparam logic [2:0] RVF3_BGEU = 3'b111;
    localparam logic [2:0] RVF3_LB   = 3'b000;
    localparam logic [2:0] RVF3_LH   = 3'b001;
    localparam logic [2:0] RVF3_LW   = 3'b010;
    localparam logic [2:0] RVF3_LBU  = 3'b100;
    localparam logic [2:0] RVF3_LHU  = 3'b101;
    localparam logic [2:0] RVF3_SB   = 3'b000;
    localparam logic [2:0] RVF3_SH   = 3'b001;
    localparam logic [2:0] RVF3_SW   = 3'b010;

    localparam logic [6:0] RVF7_ADD  = 7'b0000000;
    localparam logic [6:0] RVF7_SUB  = 7'b0100000;

endpackage

// File: rtl/sr_mc_decode.sv
// Combinational instruction classifier: class, ALU operation and branch polarity.
// o_br_zero gives the aluZero value on which a branch is taken.
module sr_mc_decode
    import sr_mc_pkg::*;
(
    input  logic [6:0]       i_op,
    input  logic [2:0]       i_f3,
    input  logic [6:0]       i_f7,
    output logic [2:0]       o_cls,
    output logic [ALU_W-1:0] o_alu,
    output logic             o_br_zero
);

    always_comb begin
        o_cls     = C_ILLEGAL;
        o_alu     = ALU_ADD;
        o_br_zero = 1'b0;
        case (i_op)
            RVOP_ALU: begin
                case ({i_f7, i_f3})
                    {RVF7_ADD, RVF3_ADD}:  begin o_cls = C_ALU; o_alu = ALU_ADD;  end
                    {RVF7_SUB, RVF3_ADD}:  begin o_cls = C_ALU; o_alu = ALU_SUB;  end
                    {RVF7_ADD, RVF3_OR}:   begin o_cls = C_ALU; o_alu = ALU_OR;   end
                    {RVF7_ADD, RVF3_SRL}:  begin o_cls = C_ALU; o_alu = ALU_SRL;  end
                    {RVF7_ADD, RVF3_SLTU}: begin o_cls = C_ALU; o_alu = ALU_SLTU; end
                    default: ;
                endcase
            end
            RVOP_ADDI:  if (i_f3 == RVF3_ADD) o_cls = C_ALU_IMM;
            RVOP_LUI:   o_cls = C_LUI;
            RVOP_LOAD: begin
                if (i_f3 inside {RVF3_LB, RVF3_LH, RVF3_LW, RVF3_LBU, RVF3_LHU}) o_cls = C_LOAD;
            end
            RVOP_STORE: if (i_f3 inside {RVF3_SB, RVF3_SH, RVF3_SW}) o_cls = C_STORE;
            RVOP_BRANCH: begin
                o_cls = C_BRANCH;
                case (i_f3)
                    RVF3_BEQ:  begin o_alu = ALU_SUB;  o_br_zero = 1'b1; end
                    RVF3_BNE:  begin o_alu = ALU_SUB;  o_br_zero = 1'b0; end
                    RVF3_BLT:  begin o_alu = ALU_SLT;  o_br_zero = 1'b0; end
                    RVF3_BGE:  begin o_alu = ALU_SLT;  o_br_zero = 1'b1; end
                    RVF3_BLTU: begin o_alu = ALU_SLTU; o_br_zero = 1'b0; end
                    RVF3_BGEU: begin o_alu = ALU_SLTU; o_br_zero = 1'b1; end
                    default:   o_cls = C_ILLEGAL;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sr_mc_control.sv
// Multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB) with data-memory timeout.
// Define SR_CTRL_TRAP_EN to trap unknown encodings in S_TRAP with an 'illegal' output.
module sr_mc_control
    import sr_mc_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W = 4,
    parameter int unsigned DM_TIMEOUT = 15,
    parameter int unsigned TMO_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            cmdOp,
    input  logic [2:0]            cmdF3,
    input  logic [6:0]            cmdF7,
    input  logic                  aluZero,
    input  logic                  imAck,
    input  logic                  dmAck,
    output logic                  imReq,
    output logic                  irWe,
    output logic                  pcWe,
    output logic                  pcSrc,
    output logic                  regWrite,
    output logic                  aluSrc,
    output logic                  wdSrc,
    output logic                  memToReg,
    output logic [1:0]            immSel,
    output logic                  dmReq,
    output logic                  dmWe,
    output logic [2:0]            dmRMode,
    output logic [ALU_CTRL_W-1:0] aluControl,
    output logic                  memErr
`ifdef SR_CTRL_TRAP_EN
    ,
    output logic                  illegal
`endif
);

    state_e           r_state;
    logic [TMO_W-1:0] r_cnt;

    logic [2:0]       w_cls_raw;
    class_e           w_cls;
    logic [ALU_W-1:0] w_alu;
    logic             w_br_zero;
    logic             w_taken;
    logic             w_tmo;
    logic [1:0]       w_imm;
    logic             w_alu_src;

    sr_mc_decode u_decode (
        .i_op      (cmdOp),
        .i_f3      (cmdF3),
        .i_f7      (cmdF7),
        .o_cls     (w_cls_raw),
        .o_alu     (w_alu),
        .o_br_zero (w_br_zero)
    );

    assign w_cls     = class_e'(w_cls_raw);
    assign w_taken   = (aluZero == w_br_zero);
    // Abort in the last allowed MEM cycle; a coincident dmAck takes priority.
    assign w_tmo     = (DM_TIMEOUT != 0) && (r_cnt == TMO_W'(DM_TIMEOUT - 1)) && !dmAck;
    assign w_alu_src = (w_cls inside {C_ALU_IMM, C_LOAD, C_STORE, C_LUI});

    always_comb begin
        case (w_cls)
            C_STORE:  w_imm = IMM_S;
            C_BRANCH: w_imm = IMM_B;
            C_LUI:    w_imm = IMM_U;
            default:  w_imm = IMM_I;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_FETCH:  if (imAck) r_state <= S_DECODE;
                S_DECODE: begin
                    if (w_cls == C_ILLEGAL) begin
`ifdef SR_CTRL_TRAP_EN
                        r_state <= S_TRAP;
`else
                        r_state <= S_FETCH;
`endif
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (w_cls)
                        C_LOAD, C_STORE: r_state <= S_MEM;
                        C_BRANCH:        r_state <= S_FETCH;
                        default:         r_state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (dmAck || w_tmo) begin
                        r_state <= S_FETCH;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                S_WB:    r_state <= S_FETCH;
                S_TRAP:  r_state <= S_TRAP;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        imReq      = 1'b0;
        irWe       = 1'b0;
        pcWe       = 1'b0;
        pcSrc      = 1'b0;
        regWrite   = 1'b0;
        aluSrc     = 1'b0;
        wdSrc      = 1'b0;
        memToReg   = 1'b0;
        immSel     = IMM_I;
        dmReq      = 1'b0;
        dmWe       = 1'b0;
        dmRMode    = 3'b000;
        aluControl = '0;
        memErr     = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    imReq = 1'b1;
                    irWe  = imAck;
                    pcWe  = imAck;
                end
                S_DECODE: immSel = w_imm;
                S_EXEC: begin
                    immSel     = w_imm;
                    aluSrc     = w_alu_src;
                    aluControl = ALU_CTRL_W'(w_alu);
                    if (w_cls == C_BRANCH) begin
                        pcSrc = 1'b1;
                        pcWe  = w_taken;
                    end
                end
                S_MEM: begin
                    immSel     = w_imm;
                    aluSrc     = w_alu_src;
                    aluControl = ALU_CTRL_W'(w_alu);
                    dmReq      = 1'b1;
                    dmWe       = (w_cls == C_STORE);
                    dmRMode    = cmdF3;
                    if (dmAck) begin
                        memToReg = (w_cls == C_LOAD);
                        regWrite = (w_cls == C_LOAD);
                    end else if (w_tmo) begin
                        memErr = 1'b1;
                    end
                end
                S_WB: begin
                    immSel     = w_imm;
                    aluSrc     = w_alu_src;
                    aluControl = ALU_CTRL_W'(w_alu);
                    regWrite   = 1'b1;
                    wdSrc      = (w_cls == C_LUI);
                end
                default: ;
            endcase
        end
    end

`ifdef SR_CTRL_TRAP_EN
    assign illegal = rst_n && (r_state == S_TRAP);
`endif

endmodule

// File: doc/sr_mc_control.md
Name: sr_mc_control

Overview:
Multi-cycle control unit for the schoolRISCV core; successor to the single-cycle decoder. Decodes the latched instruction and sequences FETCH/DECODE/EXEC/MEM/WB with ready/valid handshakes to instruction and data memory. Adds loads/stores, the full conditional-branch set and a data-memory timeout. Sits between the instruction register and the multi-cycle datapath. PC, IR, ALU and register file stay in the datapath.

Parameters:
ALU_CTRL_W, 4, width of aluControl; the ALU_* codes in the package are sized to this.
DM_TIMEOUT, 15, max cycles in MEM without dmAck before abort; 0 = wait forever.
TMO_W, 4, timeout counter width; must satisfy 2^TMO_W > DM_TIMEOUT.

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
cmdOp  in  7  opcode from IR
cmdF3  in  3  funct3 from IR
cmdF7  in  7  funct7 from IR
aluZero  in  1  ALU result == 0
imAck  in  1  instruction memory data valid
dmAck  in  1  data memory access complete
imReq  out  1  instruction fetch request
irWe  out  1  latch instruction into IR
pcWe  out  1  PC update strobe
pcSrc  out  1  0: PC+4, 1: PC+immB
regWrite  out  1  register file write strobe
aluSrc  out  1  0: rs2, 1: imm
wdSrc  out  1  1: immU (LUI) to write-back
memToReg  out  1  1: load data to write-back
immSel  out  2  0 I, 1 S, 2 B, 3 U
dmReq  out  1  data memory request
dmWe  out  1  data memory write (valid with dmReq)
dmRMode  out  3  load/store size = funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
aluControl  out  ALU_CTRL_W  ALU operation
memErr  out  1  one-cycle pulse on data timeout

Behaviour:
- Reset (rst_n low at posedge): state <= S_FETCH, timeout counter <= 0. All outputs 0 while rst_n is low. A mid-operation reset drops any pending request with no write-back.
- Outputs are Moore-decoded from the state and the latched instruction. irWe, pcWe-on-fetch and regWrite-after-load are qualified by the ack.
- S_FETCH: imReq=1. Wait until imAck, then irWe=1, pcWe=1 (pcSrc=0) in that cycle; go to S_DECODE.
- S_DECODE: one cycle, immSel valid. Go to S_EXEC. An unknown encoding is treated as NOP and goes to S_FETCH.
- S_EXEC: drive aluSrc/aluControl.
  - R/I-type ALU and LUI: go to S_WB.
  - Load/store: ALU_ADD, aluSrc=1, immSel I/S; go to S_MEM.
  - Branch: pcWe = branch taken, pcSrc=1; go to S_FETCH.
- Branch conditions:
  - BEQ/BNE: ALU_SUB; taken on aluZero=1 (BEQ) or aluZero=0 (BNE).
  - BLT/BGE: ALU_SLT; taken on aluZero=0 (BLT) or aluZero=1 (BGE).
  - BLTU/BGEU: ALU_SLTU, same conditions.
- S_MEM: dmReq=1, dmWe=1 for stores, dmRMode=cmdF3, counter increments each cycle.
  - On dmAck: a load does memToReg=1 and regWrite=1 in the same cycle, then goes to S_FETCH; a store goes to S_FETCH.
  - Counter reaching DM_TIMEOUT with no dmAck: memErr=1, no write, go to S_FETCH. dmAck in the timeout cycle wins.
  - Counter clears on leaving S_MEM.
- S_WB: regWrite=1 (wdSrc=1 for LUI). Go to S_FETCH.
- Cycle counts with zero-wait acks: ALU op 4, load 4, store 4, branch 3.
- imAck/dmAck are ignored outside S_FETCH/S_MEM.
- Writes to rd=x0 are suppressed by the register file, not here.

Optional Feature:
SR_CTRL_TRAP_EN:
- Defined: adds output illegal (1 bit) and state S_TRAP. An unknown encoding in S_DECODE goes to S_TRAP. S_TRAP holds illegal=1 and all strobes 0 until reset.
- Undefined: unknown encodings are a NOP, and the port is absent.

Decomposition:
- Package sr_mc_pkg holds:
  - state enum (S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP)
  - IMM_I/S/B/U codes
  - ALU_* codes
  - RVOP/RVF3/RVF7 constants for the new load, store and branch opcodes
- One sub-module, sr_mc_decode: combinational classification of {cmdF7, cmdF3, cmdOp} into class (alu, aluImm, lui, load, store, branch, illegal) plus aluControl and branch condition. The top holds the FSM and timeout counter.

Test Plan:
- Reset held 3 cycles mid-S_MEM, then released with imAck=1 → all outputs 0 during reset; imReq=1 on the first cycle after release; no regWrite.
- ADD, imAck after 2 wait cycles → irWe exactly once; regWrite in cycle 6; aluControl=ALU_ADD in S_EXEC.
- LW (F3=010), dmAck=1 in second S_MEM cycle → dmReq high 2 cycles, dmRMode=3'b010, dmWe=0; memToReg=regWrite=1 only in the ack cycle.
- SB, dmAck same cycle → dmReq=dmWe=1 for one cycle, immSel=1, regWrite never asserts.
- BGE with aluZero=1 → pcWe=1, pcSrc=1 in S_EXEC. BLT with aluZero=1 → pcWe=0, back to S_FETCH.
- LW with dmAck never, DM_TIMEOUT=15 → memErr pulses once after 15 MEM cycles; no regWrite; next cycle imReq=1.
